// File: rtl/logic_unit_pkg.sv
// Shared types and widths for the registered bitwise logic unit.
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NAND  = 3'd2,
    OP_NOR   = 3'd3,
    OP_NOTB  = 3'd4,
    OP_XOR   = 3'd5,
    OP_XNOR  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise function select; the WIDTH-bit generalisation of the old 1-bit gate set.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f
);

  always_comb begin
    f = '0;
    case (op_e'(op))
      OP_AND:   f = op_a & b;
      OP_OR:    f = op_a | b;
      OP_NAND:  f = ~(op_a & b);
      OP_NOR:   f = ~(op_a | b);
      OP_NOTB:  f = ~b;
      OP_XOR:   f = op_a ^ b;
      OP_XNOR:  f = ~(op_a ^ b);
      OP_PASSA: f = op_a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Valid/ready wrapped logic unit with one result register stage, result flags and a chaining accumulator.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             chain,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] f;
  logic             accept;

  // Slot is free when empty or being drained this cycle, giving one result per cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign op_a     = chain ? acc : a;

  logic_unit_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op  (op),
    .op_a(op_a),
    .b   (b),
    .f   (f)
  );

  // Result register and flags; values hold after drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      parity    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= f;
      zero      <= ~|f;
      parity    <= ^f;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear beats a same-cycle accept; the accepted result still used the old acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (accept) begin
      acc <= f;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus randomized traffic against a transaction-level model.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       chain;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       parity;

  int total = 0;
  int bad   = 0;

  // model state
  logic [7:0] m_acc;
  logic       m_valid;
  logic [7:0] m_y;
  logic       m_zero;
  logic       m_par;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .chain    (chain),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .zero     (zero),
    .parity   (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-bit truth table lookup, indexed by {a_bit, b_bit}.
  function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    logic [3:0] tt;
    logic [7:0] r;
    case (o)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0111;
      3'd3:    tt = 4'b0001;
      3'd4:    tt = 4'b0101;
      3'd5:    tt = 4'b0110;
      3'd6:    tt = 4'b1001;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{x[i], z[i]}];
    return r;
  endfunction

  task automatic model_reset();
    m_acc = 8'h00; m_valid = 1'b0; m_y = 8'h00; m_zero = 1'b0; m_par = 1'b0;
  endtask

  task automatic drive(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [2:0] iop, input logic ich, input logic iclr, input logic ordy);
    in_valid = iv; a = ia; b = ib; op = iop; chain = ich; acc_clr = iclr; out_ready = ordy;
  endtask

  // Advance one clock, applying the transaction rules to the model at the edge.
  task automatic tick();
    logic       rdy;
    logic       acc_ok;
    logic [7:0] r;
    @(posedge clk);
    rdy    = !m_valid || out_ready;
    acc_ok = in_valid && rdy;
    r      = ref_f(op, chain ? m_acc : a, b);
    if (acc_ok) begin
      m_valid = 1'b1; m_y = r; m_zero = (r == 8'h00); m_par = ($countones(r) % 2) == 1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (acc_clr) m_acc = 8'h00;
    else if (acc_ok) m_acc = r;
    #1;
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (y !== 8'h00) begin bad++; $display("FAIL rst_y: got %h want 00", y); end
    total++; if (zero !== 1'b0 || parity !== 1'b0) begin bad++; $display("FAIL rst_flags: got z=%b p=%b want 0 0", zero, parity); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    drive(1, 8'hFE, 8'h00, 3'd7, 0, 0, 0);
    tick();
    drive(0, 8'h00, 8'h00, 3'd0, 0, 0, 0);
    total++; if (y !== 8'hFE || out_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_load: got y=%h v=%b want fe 1", y, out_valid); end
    mid_reset();
    total++; if (out_valid !== 1'b0 || y !== 8'h00) begin bad++; $display("FAIL async_rst: got y=%h v=%b want 00 0", y, out_valid); end
    release_reset();
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_y [8];
    exp_y = '{8'h42, 8'hDB, 8'hBD, 8'h24, 8'hA5, 8'h99, 8'h66, 8'hC3};
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'hC3, 8'h5A, 3'(i), 0, 0, 1);
      tick();
      total++;
      if (y !== exp_y[i] || parity !== 1'b0 || out_valid !== 1'b1)
        begin bad++; $display("FAIL sweep_op%0d: got y=%h p=%b v=%b want %h 0 1", i, y, parity, out_valid, exp_y[i]); end
    end
  endtask

  task automatic test_flags();
    drive(1, 8'hF0, 8'h0F, 3'd0, 0, 0, 1);
    tick();
    total++; if (y !== 8'h00 || zero !== 1'b1 || parity !== 1'b0) begin bad++; $display("FAIL flags_and: got y=%h z=%b p=%b want 00 1 0", y, zero, parity); end
    drive(1, 8'h01, 8'h00, 3'd5, 0, 0, 1);
    tick();
    total++; if (y !== 8'h01 || zero !== 1'b0 || parity !== 1'b1) begin bad++; $display("FAIL flags_xor: got y=%h z=%b p=%b want 01 0 1", y, zero, parity); end
  endtask

  task automatic test_chain();
    drive(1, 8'h0F, 8'h00, 3'd7, 0, 0, 1);
    tick();
    total++; if (y !== 8'h0F) begin bad++; $display("FAIL chain_load: got %h want 0f", y); end
    drive(1, 8'hAA, 8'hFF, 3'd5, 1, 0, 1);
    tick();
    total++; if (y !== 8'hF0) begin bad++; $display("FAIL chain_xor1: got %h want f0", y); end
    drive(1, 8'hAA, 8'hF0, 3'd5, 1, 0, 1);
    tick();
    total++; if (y !== 8'h00 || zero !== 1'b1) begin bad++; $display("FAIL chain_xor2: got y=%h z=%b want 00 1", y, zero); end
    drive(1, 8'h55, 8'h33, 3'd5, 1, 1, 1);
    tick();
    total++; if (y !== 8'h33) begin bad++; $display("FAIL chain_clr_accept: got %h want 33", y); end
    drive(1, 8'hAA, 8'h00, 3'd7, 1, 0, 1);
    tick();
    total++; if (y !== 8'h00 || zero !== 1'b1) begin bad++; $display("FAIL chain_after_clr: got y=%h z=%b want 00 1", y, zero); end
    // a clear with no accept still empties the accumulator
    drive(1, 8'h3C, 8'h00, 3'd7, 0, 0, 1);
    tick();
    drive(0, 8'h00, 8'h00, 3'd0, 0, 1, 1);
    tick();
    drive(1, 8'hAA, 8'h00, 3'd7, 1, 0, 1);
    tick();
    total++; if (y !== 8'h00) begin bad++; $display("FAIL clr_idle: got %h want 00", y); end
  endtask

  task automatic test_backpressure();
    drive(1, 8'h11, 8'h00, 3'd7, 0, 0, 1);
    tick();
    drive(1, 8'h22, 8'h00, 3'd7, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d: got %b want 0", i, in_ready); end
      tick();
      total++; if (y !== 8'h11 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d: got y=%h v=%b want 11 1", i, y, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    total++; if (y !== 8'h22 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_release: got y=%h v=%b want 22 1", y, out_valid); end
    drive(0, 8'h00, 8'h00, 3'd0, 0, 0, 1);
    tick();
    total++; if (y !== 8'h22 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got y=%h v=%b want 22 0", y, out_valid); end
  endtask

  task automatic test_bubbles();
    drive(1, 8'h10, 8'h00, 3'd7, 0, 0, 1);
    tick();
    total++; if (out_valid !== 1'b1 || y !== 8'h10) begin bad++; $display("FAIL bubble0: got y=%h v=%b want 10 1", y, out_valid); end
    drive(0, 8'h99, 8'h00, 3'd7, 0, 0, 1);
    tick();
    total++; if (out_valid !== 1'b0 || y !== 8'h10) begin bad++; $display("FAIL bubble1: got y=%h v=%b want 10 0", y, out_valid); end
    drive(1, 8'h20, 8'h00, 3'd7, 0, 0, 1);
    tick();
    total++; if (out_valid !== 1'b1 || y !== 8'h20) begin bad++; $display("FAIL bubble2: got y=%h v=%b want 20 1", y, out_valid); end
  endtask

  task automatic test_reset_stall();
    drive(1, 8'h77, 8'h00, 3'd7, 0, 0, 1);
    tick();
    drive(0, 8'h00, 8'h00, 3'd0, 0, 0, 0);
    tick();
    mid_reset();
    total++; if (out_valid !== 1'b0 || y !== 8'h00) begin bad++; $display("FAIL stall_rst: got y=%h v=%b want 00 0", y, out_valid); end
    release_reset();
    drive(1, 8'h5A, 8'h00, 3'd7, 1, 0, 1);
    tick();
    total++; if (y !== 8'h00 || zero !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_rst_acc: got y=%h z=%b v=%b want 00 1 1", y, zero, out_valid); end
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
      #1;
      exp_rdy = !m_valid || out_ready;
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rand_ready@%0d: got %b want %b", i, in_ready, exp_rdy); end
      tick();
      total++;
      if (out_valid !== m_valid || y !== m_y || zero !== m_zero || parity !== m_par)
        begin bad++; $display("FAIL rand_out@%0d: got v=%b y=%h z=%b p=%b want %b %h %b %b", i, out_valid, y, zero, parity, m_valid, m_y, m_zero, m_par); end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 8'h00, 3'd0, 0, 0, 0);
    model_reset();
    #12;
    release_reset();
    test_reset();
    test_op_sweep();
    test_flags();
    test_chain();
    test_backpressure();
    test_bubbles();
    test_reset_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, registered bitwise logic unit and the successor to the fixed 1-bit gate block. It takes WIDTH-bit operands and an opcode that selects AND, OR, NAND, NOR, NOT-B, XOR, XNOR or PASS-A. Input and output use a valid/ready handshake, with one output register stage. An internal accumulator lets chained operations replace operand A with the previous result. It sits between operand producers and consumers in the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand/op presented
in_ready  output  1  unit can accept this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select (encoding below)
chain  input  1  1 = use accumulator in place of a
acc_clr  input  1  synchronous accumulator clear
out_valid  output  1  result register holds valid data
out_ready  input  1  consumer accepts result
y  output  WIDTH  result
zero  output  1  y == 0
parity  output  1  XOR-reduction of y

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values (async, immediate): out_valid=0, y=0, zero=0, parity=0, acc=0.
- op encoding:
  - 0 AND, 1 OR, 2 NAND, 3 NOR.
  - 4 NOTB (~b, a ignored), 5 XOR, 6 XNOR, 7 PASSA (y=opA).
- Operand A selection: opA = chain ? acc : a. The acc value used is the value before this cycle's update.
- Ready rule: in_ready = !out_valid || out_ready. This is combinational and gives full throughput, 1 result/cycle.
- Accept: occurs when in_valid && in_ready. On the next clk edge:
  - y <= f(op, opA, b)
  - zero <= (f == 0)
  - parity <= ^f
  - out_valid <= 1
- Latency: 1 cycle from accept to out_valid.
- Output drain: out_valid && out_ready with no new accept gives out_valid <= 0. y, zero and parity keep their last values.
- Stall: while out_valid && !out_ready, y/zero/parity/out_valid are held stable and in_ready=0. No input is lost.
- Accumulator update:
  - Every accept gives acc <= f (chained or not).
  - acc_clr=1 gives acc <= 0, and wins over a simultaneous accept. The output of that accept still uses the old acc.
  - acc_clr is independent of in_valid/in_ready.
- Width rules: all ops are bitwise over WIDTH bits, with no carries. NOTB and NAND/NOR/XNOR invert all WIDTH bits.
- Reset mid-operation: any pending result is discarded and acc=0. No transfer completes in the reset cycle.
- in_valid may drop without being accepted; there is no obligation to hold. Data is sampled only on accept.

Decomposition:
- Package logic_unit_pkg:
  - op_e enum (OP_AND..OP_PASSA, 3 bits)
  - OP_W=3
  - a function for parity-reduction, if the toolflow allows package functions
- Sub-module logic_unit_core: purely combinational.
  - Inputs: op, opA, b. Output: f.
  - Parametrised by WIDTH.
  - Holds the case over op_e. It is the direct generalisation of the original gate set.
- Top logic_unit_pipe holds the handshake, the result register, the flags and acc.

Test Plan:
- Reset and op sweep (WIDTH=8): rst pulse mid-cycle drives out_valid=0 and y=0 immediately. Then a=0xC3, b=0x5A, chain=0, op 0..7 back-to-back with out_ready=1 -> y = 0x42, 0xDB, 0xBD, 0x24, 0xA5, 0x99, 0x66, 0xC3. Each result appears 1 cycle after accept, with parity = 0,0,0,0,0,0,0,0, and out_valid stays 1 throughout.
- Flags: a=0xF0, b=0x0F, op=AND -> y=0x00, zero=1, parity=0. Then op=XOR, a=0x01, b=0x00 -> y=0x01, zero=0, parity=1.
- Chaining: PASSA a=0x0F gives acc=0x0F. XOR chain=1 b=0xFF gives y=0xF0. XOR chain=1 b=0xF0 gives y=0x00, zero=1. Then acc_clr=1 together with an accepted XOR chain=1 b=0x33 gives y=0x33 (old acc=0x00) and acc=0. A following PASSA chain=1 gives y=0x00.
- Backpressure: result pending, out_ready=0 for 3 cycles with in_valid=1 and new operands -> in_ready=0 and y stable for all 3 cycles. When out_ready=1, the held input is accepted that cycle and its result appears on the next edge. No drop, no duplicate.
- Bubbles: in_valid toggling 1,0,1 with out_ready=1 -> out_valid toggles 1,0,1 one cycle later. y holds its last value during the bubble.
- Reset during stall: out_valid=1, out_ready=0, assert rst -> out_valid=0 and acc=0 asynchronously. After release, the first accept with chain=1, op=PASSA gives y=0x00.
